// File: rtl/inst_encoder.sv
// RV32I field-bundle encoder and instruction-memory loader.
// Legal bundles become one registered write to consecutive word addresses; illegal ones are counted and dropped.
module inst_encoder #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    kind,
    input  logic [2:0]    f3,
    input  logic          f7b5,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [31:0]   imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err,
    output logic [7:0]    err_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic        accept;
    logic        legal;
    logic [31:0] word;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        is_shift;
    logic        we_q;

    // Signed-fit tests: every bit above the sign bit must replicate it.
    assign fits12   = (imm[31:11] == {21{imm[11]}});
    assign fits13   = (imm[31:12] == {20{imm[12]}});
    assign fits21   = (imm[31:20] == {12{imm[20]}});
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign full     = count[AW];
    assign in_ready = ~rst & ~clr & ~full;
    assign accept   = in_valid & in_ready;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (kind)
            3'd0: begin
                word  = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_R};
                legal = !(f7b5 && (f3 != 3'b000) && (f3 != 3'b101));
            end
            3'd1: begin
                if (is_shift) begin
                    word  = {1'b0, f7b5, 5'b0, imm[4:0], rs1, f3, rd, OP_IALU};
                    legal = (imm[31:5] == 27'd0);
                end else begin
                    word  = {imm[11:0], rs1, f3, rd, OP_IALU};
                    legal = fits12;
                end
                if (f7b5 && (f3 != 3'b101)) begin
                    legal = 1'b0;
                end
            end
            3'd2: begin
                word  = {imm[11:0], rs1, f3, rd, OP_LOAD};
                legal = fits12 && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            3'd3: begin
                word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
                legal = fits12 && (f3 <= 3'b010);
            end
            3'd4: begin
                word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
                legal = fits13 && !imm[0] && (f3 != 3'b010) && (f3 != 3'b011);
            end
            3'd5: begin
                word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                legal = fits12 && (f3 == 3'b000);
            end
            3'd6: begin
                word  = {imm[31:12], rd, OP_LUI};
                legal = (imm[11:0] == 12'd0);
            end
            default: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                legal = fits21 && !imm[0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else if (clr) begin
            we_q    <= 1'b0;
            count   <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            we_q <= accept && legal;
            if (accept && legal) begin
                imem_addr  <= count[AW-1:0];
                imem_wdata <= word;
                count      <= count + (AW+1)'(1);
            end
            if (accept && !legal) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

    // A write registered just before rst is suppressed rather than issued.
    assign imem_we = we_q & ~rst;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed program-loading scenarios plus randomized bundles
// checked cycle by cycle against an arithmetic reference of the RV32I packing rules.
module tb_inst_encoder;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, clr, in_valid;
    logic          in_ready;
    logic [2:0]    kind, f3;
    logic          f7b5;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full, err;
    logic [7:0]    err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    int          m_count;
    bit          m_err;
    int          m_errcnt;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_data;

    logic [6:0] opc [0:7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h6F};

    inst_encoder #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .f3(f3), .f7b5(f7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h expected=%08h at %0t", tag, got, exp, $time);
    endtask

    // Reference: builds the word from the published field layouts and legality rules.
    function automatic logic [32:0] ref_enc(input logic [2:0] k, input logic [2:0] fn3, input logic f7,
                                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                            input logic [31:0] im);
        logic [31:0] w, op, base;
        bit ok, in12;
        int s, f;
        s    = int'($signed(im));
        f    = int'(fn3);
        in12 = (s >= -2048) && (s <= 2047);
        op   = 32'(opc[k]);
        base = op | (32'(d) << 7) | (32'(fn3) << 12) | (32'(s1) << 15);
        ok   = 1;
        w    = 0;
        case (int'(k))
            0: begin
                w  = base | (32'(s2) << 20) | (32'(f7) << 30);
                ok = !(f7 && f != 0 && f != 5);
            end
            1: begin
                if (f == 1 || f == 5) begin
                    ok = (im >> 5) == 0;
                    w  = base | ((im & 31) << 20) | (32'(f7) << 30);
                end else begin
                    ok = in12;
                    w  = base | ((im & 32'hFFF) << 20);
                end
                if (f7 && f != 5) ok = 0;
            end
            2: begin
                ok = in12 && f != 3 && f < 6;
                w  = base | ((im & 32'hFFF) << 20);
            end
            3: begin
                ok = in12 && f <= 2;
                w  = op | ((im & 31) << 7) | (32'(fn3) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
                     | (((im >> 5) & 127) << 25);
            end
            4: begin
                ok = f != 2 && f != 3 && s >= -4096 && s <= 4094 && (s % 2 == 0);
                w  = op | (((im >> 11) & 1) << 7) | (((im >> 1) & 15) << 8) | (32'(fn3) << 12)
                     | (32'(s1) << 15) | (32'(s2) << 20) | (((im >> 5) & 63) << 25) | (((im >> 12) & 1) << 31);
            end
            5: begin
                ok = in12 && f == 0;
                w  = op | (32'(d) << 7) | (32'(s1) << 15) | ((im & 32'hFFF) << 20);
            end
            6: begin
                ok = (im & 32'hFFF) == 0;
                w  = op | (32'(d) << 7) | (im & 32'hFFFFF000);
            end
            default: begin
                ok = s >= -1048576 && s <= 1048574 && (s % 2 == 0);
                w  = op | (32'(d) << 7) | (((im >> 12) & 255) << 12) | (((im >> 11) & 1) << 20)
                     | (((im >> 1) & 1023) << 21) | (((im >> 20) & 1) << 31);
            end
        endcase
        return {ok, w};
    endfunction

    task automatic model_reset();
        m_count = 0; m_err = 0; m_errcnt = 0; m_we = 0; m_addr = 0; m_data = 0;
    endtask

    // One clock: check every output against the model, then advance the model over the edge.
    task automatic cycle();
        bit acc;
        logic [32:0] r;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!rst && !clr && m_count != CAP));
        chk("imem_we", 32'(imem_we), 32'(m_we && !rst));
        chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        chk("imem_wdata", imem_wdata, m_data);
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == CAP));
        chk("err", 32'(err), 32'(m_err));
        chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
        acc = in_valid && !rst && !clr && m_count != CAP;
        r   = ref_enc(kind, f3, f7b5, rd, rs1, rs2, imm);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (clr) begin
            m_count = 0; m_err = 0; m_errcnt = 0; m_we = 0;
        end else if (acc && r[32]) begin
            m_we = 1; m_addr = m_count; m_data = r[31:0]; m_count++;
        end else begin
            m_we = 0;
            if (acc) begin
                m_err = 1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input int k, input int fn3, input logic f7,
                         input int d, input int s1, input int s2, input int im);
        in_valid = v; kind = 3'(k); f3 = 3'(fn3); f7b5 = f7;
        rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 32'(im);
    endtask

    task automatic idle();
        in_valid = 0;
    endtask

    task automatic expect_word(input string tag, input int addr, input logic [31:0] w);
        chk({tag, "_we"}, 32'(imem_we), 32'd1);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
        chk({tag, "_data"}, imem_wdata, w);
    endtask

    task automatic do_clr();
        idle(); clr = 1; cycle(); clr = 0;
    endtask

    function automatic int pick_imm();
        int b[13] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                      1048574, -1048576, 1048576, 31, 32};
        case ($urandom_range(0, 7))
            0: return int'($urandom_range(0, 40)) - 20;
            1: return int'($urandom);
            2: return b[$urandom_range(0, 12)];
            3: return int'($urandom & 32'hFFFFF000);
            4: return int'($urandom_range(0, 4095)) - 2048;
            5: return (int'($urandom_range(0, 8191)) - 4096) & ~1;
            6: return (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        rst = 1; clr = 0; idle(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 0;
        cycle();

        // ADD then SUB back to back
        drive(1, 0, 0, 0, 3, 1, 2, 0); cycle();
        expect_word("add", 0, 32'h002081B3);
        drive(1, 0, 0, 1, 3, 1, 2, 0); cycle();
        expect_word("sub", 1, 32'h402081B3);
        idle(); cycle();
        chk("count_two", 32'(count), 32'd2);

        do_clr();
        drive(1, 1, 5, 1, 5, 6, 0, 3); cycle();
        expect_word("srai", 0, 32'h40335293);
        drive(1, 3, 2, 0, 0, 1, 2, -4); cycle();
        expect_word("sw", 1, 32'hFE20AE23);
        drive(1, 4, 0, 0, 0, 1, 2, 8); cycle();
        expect_word("beq", 2, 32'h00208463);
        drive(1, 4, 0, 0, 0, 1, 2, 7); cycle();
        chk("beq_odd_we", 32'(imem_we), 32'd0);
        chk("beq_odd_err", 32'(err), 32'd1);
        chk("beq_odd_errcnt", 32'(err_cnt), 32'd1);
        chk("beq_odd_count", 32'(count), 32'd3);
        drive(1, 1, 0, 0, 1, 0, 0, 2048); cycle();
        chk("addi2048_errcnt", 32'(err_cnt), 32'd2);
        drive(1, 1, 0, 0, 1, 0, 0, 2047); cycle();
        expect_word("addi2047", 3, 32'h7FF00093);
        chk("full_after_fill", 32'(full), 32'd1);
        chk("ready_after_fill", 32'(in_ready), 32'd0);
        idle(); cycle();

        // five back-to-back bundles into a four-word memory
        do_clr();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 1, 0, 0, i + 1); cycle();
        end
        chk("held_count", 32'(count), 32'd4);
        chk("held_full", 32'(full), 32'd1);
        chk("held_ready", 32'(in_ready), 32'd0);
        clr = 1; cycle(); clr = 0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        cycle();
        expect_word("fifth", 0, 32'h00500093);
        idle(); cycle();

        // rst right after an accept swallows the pending write
        drive(1, 6, 0, 0, 7, 0, 0, 32'h12345000); cycle();
        rst = 1; idle(); #1;
        chk("rst_we_gate", 32'(imem_we), 32'd0);
        cycle();
        rst = 0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        cycle();

        // err_cnt saturation
        drive(1, 6, 0, 0, 1, 0, 0, 1);
        repeat (260) cycle();
        chk("errcnt_sat", 32'(err_cnt), 32'd255);
        chk("sat_count", 32'(count), 32'd0);
        do_clr();

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), pick_imm());
            clr = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 0; clr = 0; idle(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RISC-V RV32I instruction encoder and program loader. It accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit machine words, and writes them to consecutive word addresses of the instruction memory write port. Test programs and boot images are built field-by-field, and the resulting words are fed back through the core's instruction decode path. Illegal or unrepresentable field combinations are dropped and flagged; nothing is written for them.

## Interface
- AW, 8, instruction-memory word-address width; capacity is 2^AW words
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  synchronous clear of write pointer, count and error state; reset values apply
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder accepts this cycle; combinational: ~rst & ~clr & ~full
- kind  in  3  format/opcode: 0 R 0110011, 1 I-ALU 0010011, 2 LOAD 0000011, 3 STORE 0100011, 4 BRANCH 1100011, 5 JALR 1100111, 6 LUI 0110111, 7 JAL 1101111
- f3  in  3  funct3
- f7b5  in  1  funct7[5]: SUB/SRA select, R and I-shift only
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  signed byte-level immediate; LUI takes the full value with imm[11:0]=0
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  AW  word address
- imem_wdata  out  32  encoded instruction
- count  out  AW+1  legal words accepted since reset/clr
- full  out  1  count == 2^AW
- err  out  1  sticky: at least one illegal bundle accepted
- err_cnt  out  8  illegal bundles accepted; saturates at 255

## Operation
- Accept = in_valid & in_ready.
- Accepted bundles are encoded and registered. The legality check runs in the same stage.
- Field packing, standard RV32I:
  - R: {0,f7b5,00000, rs2, rs1, f3, rd, op}.
  - I-ALU: f3=001/101 puts {0,f7b5,00000, imm[4:0]} in bits 31:20. All other f3 put imm[11:0] in bits 31:20.
  - JALR: f3 forced to 000.
  - S/B/J: standard immediate scrambles.
  - LUI: imm[31:12].
- A bundle is illegal on any of the following:
  - R with f7b5=1 and f3 not in {000,101}.
  - I-ALU with f7b5=1 and f3≠101.
  - I-shift with imm[31:5]≠0.
  - LOAD f3 in {011,110,111}.
  - STORE f3>010.
  - BRANCH f3 in {010,011}.
  - JALR f3≠000.
  - I/S/LOAD/JALR imm outside −2048..2047.
  - B imm outside −4096..4094, or imm[0]=1.
  - J imm outside ±1 MiB, or imm[0]=1.
  - LUI imm[11:0]≠0.
- Legal accept:
  - Writes one word at address count[AW-1:0].
  - count increments at accept.
  - Addresses never wrap; the block stops at full.
- Illegal accept:
  - Consumed with no write.
  - Sets err; increments err_cnt (saturating).
  - count is unchanged.
- full is asserted when count reaches 2^AW. in_ready is then low until clr or rst.
- clr and in_valid in the same cycle: clr wins and nothing is accepted. A write already registered from the previous cycle still completes.
- rst mid-operation: any registered-but-unissued write is discarded and imem_we is 0 the next cycle.

## Timing
- Latency: an accept at edge N produces imem_we=1, with addr/wdata valid, for exactly the cycle after edge N. There is one write per legal accept.
- Throughput: one bundle per cycle while not full.
- count and full update at the accept edge. The cycle that accepts the last free word therefore sees in_ready fall immediately after it.
- err and err_cnt update at the accept edge.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, err=0, err_cnt=0. in_ready=0 while rst or clr is high, and 1 afterwards.
- imem_addr/imem_wdata hold their last value when imem_we=0.

## Test plan
- ADD x3,x1,x2 (kind0, f3=000, f7b5=0) then SUB (f7b5=1) -> writes 0x002081B3 @0, then 0x402081B3 @1, one cycle after each accept; count=2.
- SRAI x5,x6,3 (kind1, f3=101, f7b5=1, imm=3) -> 0x40335293. SW x2,-4(x1) (kind3, f3=010, imm=−4) -> 0xFE20AE23.
- BEQ x1,x2,+8 (kind4, f3=000, imm=8) -> 0x00208463. Same bundle with imm=7 -> no write, err=1, err_cnt=1, count unchanged.
- ADDI with imm=2048 -> dropped, err_cnt increments. A following ADDI imm=2047 is written normally at the next address.
- AW=2, five back-to-back bundles with in_valid held -> four writes @0..3; full=1 and in_ready=0 from the edge of the 4th accept; the 5th is held. A clr pulse -> count=0, err=0, and the 5th is accepted and written @0.
- rst asserted the cycle after an accept -> no imem_we pulse; all outputs at reset values next cycle.
